fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of rd_count.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  in  1  run request; high = drain the FIFO continuously.
REQ-006 SHALL have port rd_en  out  1  read strobe to the synchronous FIFO.
REQ-007 SHALL have port data_out  in  FIFO_WIDTH  FIFO read data, valid after the edge that samples rd_en high.
REQ-008 SHALL have port empty  in  1  FIFO empty flag.
REQ-009 SHALL have port underflow  in  1  FIFO underflow flag.
REQ-010 SHALL have port m_data  out  FIFO_WIDTH  downstream data.
REQ-011 SHALL have port m_valid  out  1  downstream valid.
REQ-012 SHALL have port m_ready  in  1  downstream ready.
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-014 SHALL have port err_underflow  out  1  sticky underflow error.
REQ-015 SHALL have port clr_err  in  1  clears err_underflow.
REQ-016 SHALL have port rd_count  out  CNT_WIDTH  count of delivered words.

Function
REQ-017 SHALL implement states IDLE, RUN, FLUSH; IDLE->RUN when en=1; RUN->FLUSH when en=0; FLUSH->RUN when en=1 (priority); FLUSH->IDLE when inflight=0 and occ=0.
REQ-018 SHALL keep a 1-bit inflight register, loaded each edge with the current rd_en value.
REQ-019 SHALL keep a 2-entry in-order output buffer with occupancy occ (0..2); m_valid = (occ != 0); m_data = oldest entry.
REQ-020 SHALL drive rd_en combinationally = (state==RUN) & !empty & (occ + inflight - pop < 2), where pop = m_valid & m_ready.
REQ-021 SHALL push data_out into the buffer on every edge where inflight=1; the word is visible on m_data with m_valid=1 immediately after that edge.
REQ-022 SHALL pop the oldest entry on every edge where m_valid & m_ready; simultaneous push and pop SHALL leave occ unchanged and preserve order.
REQ-023 SHALL sustain one word per cycle when the FIFO stays non-empty and m_ready stays high.
REQ-024 SHALL never overflow its buffer; occ+inflight SHALL never exceed 2.
REQ-025 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-026 SHALL never assert rd_en in IDLE or FLUSH; FLUSH SHALL complete in-flight reads and deliver all buffered words.
REQ-027 SHALL set err_underflow on any edge sampling underflow=1; clr_err=1 clears it; set SHALL win over simultaneous clear.
REQ-028 SHALL assert busy combinationally from state (busy=1 in RUN and FLUSH).

Reset
REQ-029 SHALL, on rst_n low, asynchronously force state=IDLE, inflight=0, occ=0, m_valid=0, m_data=0, err_underflow=0, rd_count=0; rd_en=0 and busy=0 follow.
REQ-030 SHALL discard buffered and in-flight words on reset mid-operation; no word is delivered after reset release until a new read.

Configuration
REQ-031 SHALL, with macro FIFO_READER_COUNT_EN defined, increment rd_count on every m_valid & m_ready edge, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-032 SHALL, without FIFO_READER_COUNT_EN, tie rd_count to 0 and implement no counter logic.

Verification
REQ-033 SHALL cover: FIFO preloaded 0x0001..0x0004, en=1, m_ready=1 -> m_data 0x0001..0x0004 on consecutive cycles, then rd_en=0 once empty=1.
REQ-034 SHALL cover: 3 words queued, m_ready=0 -> exactly 2 rd_en pulses, m_data holds first word; m_ready=1 -> all 3 delivered in order.
REQ-035 SHALL cover: en dropped while 1 read in flight and occ=1 -> FLUSH, no new rd_en, both words delivered, then IDLE, busy=0.
REQ-036 SHALL cover: underflow forced high 1 cycle -> err_underflow=1 held; clr_err pulse -> 0; underflow and clr_err same cycle -> stays 1.
REQ-037 SHALL cover: rst_n low with occ=2 -> m_valid=0, m_data=0, rd_count=0 immediately, no delivery after release.
REQ-038 SHALL cover, with FIFO_READER_COUNT_EN: CNT_WIDTH=4, 17 handshakes -> rd_count=1; without macro -> rd_count=0 throughout.

Source files
------------

// File: rtl/fifo_reader.sv
// Drains a synchronous FIFO into a 2-entry valid/ready output buffer with IDLE/RUN/FLUSH control.
// Define FIFO_READER_COUNT_EN to enable the rd_count delivered-word counter.
module fifo_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  err_underflow,
  input  logic                  clr_err,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state;
  logic                  inflight;
  logic [1:0]            occ;
  logic [FIFO_WIDTH-1:0] head;
  logic [FIFO_WIDTH-1:0] tail;
  logic                  pop;
  logic                  push;
  logic [2:0]            level;

  assign m_valid = (occ != 2'd0);
  assign m_data  = head;
  assign pop     = m_valid & m_ready;
  assign push    = inflight;
  assign busy    = (state != IDLE);

  // Slots committed after this edge: buffered words plus the read in flight, minus the one leaving.
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en = (state == RUN) & ~empty & (level < 3'd2);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= FLUSH;
        FLUSH: begin
          if (en)                               state <= RUN;
          else if (!inflight && occ == 2'd0)    state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= rd_en;
  end

  // NOTE: the buffer words are reset too, because m_data must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= data_out;
          else             tail <= data_out;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever stays.
          if (occ == 2'd1) begin
            head <= data_out;
          end else begin
            head <= tail;
            tail <= data_out;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_underflow <= 1'b0;
    else if (underflow) err_underflow <= 1'b1;
    else if (clr_err)   err_underflow <= 1'b0;
  end

`ifdef FIFO_READER_COUNT_EN
  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (pop) count <= count + 1'b1;
  end

  assign rd_count = count;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed scenarios plus a randomized phase,
// checked against a queue-based FIFO model and an in-order delivery scoreboard.
module tb_fifo_reader;

  localparam int W  = 16;
  localparam int CW = 4;
`ifdef FIFO_READER_COUNT_EN
  localparam logic [CW-1:0] CNT_AFTER_17 = 4'd1;
`else
  localparam logic [CW-1:0] CNT_AFTER_17 = 4'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          rd_en;
  logic [W-1:0]  data_out = '0;
  logic          empty = 1'b1;
  logic          underflow;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          err_underflow;
  logic          clr_err;
  logic [CW-1:0] rd_count;

  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;
  int hs_total = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got[$];
  logic [W-1:0] w[4];

  fifo_reader #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rd_en(rd_en), .data_out(data_out),
    .empty(empty), .underflow(underflow), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .err_underflow(err_underflow),
    .clr_err(clr_err), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  // Synchronous FIFO model: a sampled read presents the word after the edge.
  always @(posedge clk) begin
    if (rd_en && fifo_q.size() > 0) begin
      data_out <= fifo_q[0];
      exp_q.push_back(fifo_q[0]);
      void'(fifo_q.pop_front());
    end
    empty <= (fifo_q.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef FIFO_READER_COUNT_EN
    return 32'(hs_total % (1 << CW));
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    logic         hs, stall, en_s;
    logic [W-1:0] d;
    #1;
    hs    = rst_n && m_valid && m_ready;
    stall = rst_n && m_valid && !m_ready;
    d     = m_data;
    en_s  = en;
    if (rst_n && rd_en) rd_pulses++;
    @(posedge clk);
    #1;
    if (hs) begin
      hs_total++;
      got.push_back(d);
      check("sb_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("sb_order", 32'(d), 32'(exp_q.pop_front()));
    end
    if (stall) begin
      check("stall_valid", 32'(m_valid), 1);
      check("stall_data", 32'(m_data), 32'(d));
    end
    if (!en_s) check("no_rd_after_en_low", 32'(rd_en), 0);
    check("rd_en_when_empty", 32'(rd_en && empty), 0);
    check("outstanding_le_2", 32'(exp_q.size() <= 2), 1);
    check("rd_count", 32'(rd_count), exp_count());
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && busy; i++) tick();
    check(tag, 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0, g0, n_load;
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; underflow = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_underflow), 0);
    check("rst_rd_count", 32'(rd_count), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_rd_en", 32'(rd_en), 0);

    // Preloaded 1..4 streams out on consecutive cycles.
    for (int i = 1; i <= 4; i++) fifo_q.push_back(W'(i));
    en = 1'b1; m_ready = 1'b1;
    lat = 0;
    while (!m_valid && lat < 20) begin tick(); lat++; end
    check("t1_latency", 32'(lat), 3);
    for (int i = 1; i <= 4; i++) begin
      check("t1_valid", 32'(m_valid), 1);
      check("t1_data", 32'(m_data), 32'(i));
      tick();
    end
    check("t1_empty", 32'(empty), 1);
    check("t1_rd_en_off", 32'(rd_en), 0);
    en = 1'b0;
    wait_idle("t1_idle");

    // Backpressure: two reads fill the buffer, head holds, then all three drain in order.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin w[i] = W'($urandom); fifo_q.push_back(w[i]); end
    p0 = rd_pulses; en = 1'b1;
    repeat (8) tick();
    check("t2_pulses", 32'(rd_pulses - p0), 2);
    check("t2_hold_valid", 32'(m_valid), 1);
    check("t2_hold_data", 32'(m_data), 32'(w[0]));
    g0 = got.size(); m_ready = 1'b1;
    for (int i = 0; i < 20 && got.size() < g0 + 3; i++) tick();
    check("t2_count", 32'(got.size() - g0), 3);
    for (int i = 0; i < 3; i++)
      if (g0 + i < got.size()) check("t2_order", 32'(got[g0+i]), 32'(w[i]));
    en = 1'b0;
    wait_idle("t2_idle");

    // Drop en with one word buffered and one read in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin w[i] = W'($urandom); fifo_q.push_back(w[i]); end
    p0 = rd_pulses; g0 = got.size(); en = 1'b1;
    for (int i = 0; i < 12 && rd_pulses - p0 < 2; i++) tick();
    check("t3_occ1", 32'(m_valid), 1);
    check("t3_outstanding", 32'(exp_q.size()), 2);
    en = 1'b0;
    tick();
    check("t3_flush_busy", 32'(busy), 1);
    m_ready = 1'b1;
    wait_idle("t3_idle");
    check("t3_no_new_reads", 32'(rd_pulses - p0), 2);
    check("t3_delivered", 32'(got.size() - g0), 2);
    check("t3_valid_off", 32'(m_valid), 0);
    for (int i = 0; i < 2; i++)
      if (g0 + i < got.size()) check("t3_order", 32'(got[g0+i]), 32'(w[i]));
    fifo_q.delete();
    tick();

    // Sticky underflow error; set beats a simultaneous clear.
    underflow = 1'b1; tick(); underflow = 1'b0;
    check("t4_set", 32'(err_underflow), 1);
    repeat (3) tick();
    check("t4_held", 32'(err_underflow), 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("t4_clr", 32'(err_underflow), 0);
    underflow = 1'b1; clr_err = 1'b1; tick(); underflow = 1'b0; clr_err = 1'b0;
    check("t4_set_wins", 32'(err_underflow), 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("t4_clr2", 32'(err_underflow), 0);

    // Reset mid-operation with a full buffer.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_q.push_back(W'($urandom));
    en = 1'b1;
    repeat (6) tick();
    check("t5_full_valid", 32'(m_valid), 1);
    check("t5_full_outstanding", 32'(exp_q.size()), 2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(m_valid), 0);
    check("t5_rst_data", 32'(m_data), 0);
    check("t5_rst_count", 32'(rd_count), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_rd_en", 32'(rd_en), 0);
    exp_q.delete(); hs_total = 0; en = 1'b0; m_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_no_delivery", 32'(m_valid), 0);
    end
    fifo_q.delete();
    tick();

    // Seventeen handshakes from reset wrap a 4-bit counter to 1.
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) fifo_q.push_back(W'($urandom));
    en = 1'b1;
    for (int i = 0; i < 80 && hs_total < 17; i++) tick();
    check("t6_handshakes", 32'(hs_total), 17);
    en = 1'b0;
    wait_idle("t6_idle");
    check("t6_rd_count", 32'(rd_count), 32'(CNT_AFTER_17));

    // Randomized traffic with en and m_ready toggling.
    n_load = 0; g0 = got.size();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin fifo_q.push_back(W'($urandom)); n_load++; end
      en      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 2000 && (fifo_q.size() > 0 || exp_q.size() > 0); i++) tick();
    en = 1'b0;
    wait_idle("rnd_idle");
    check("rnd_all_delivered", 32'(got.size() - g0), 32'(n_load));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
